// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined add/subtract unit.
// Optional feature: `PIPELINED_ADDER_SATURATE_EN adds a per-op saturate bit.
package adder_pkg;

    // Operation mode as presented on in_sub
    localparam logic ADD_OP_ADD = 1'b0;
    localparam logic ADD_OP_SUB = 1'b1;

    // Per-stage control carried alongside the operand/sum slices:
    // carry into the next slice, running AND of slice-zero bits, saturate request.
    typedef struct packed {
        logic carry;
        logic zero;
`ifdef PIPELINED_ADDER_SATURATE_EN
        logic sat;
`endif
    } stage_ctl_t;

endpackage

// File: rtl/adder_slice.sv
// Combinational SLICE-bit adder with carry in/out; one instance per pipeline stage.
module adder_slice #(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] sum,
    output logic             cout
);

    // Widen by one bit so the carry falls out of the top of the sum
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, cin};

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract unit: WIDTH-bit add split into STAGES carry-chained
// slices, one slice per clock stage, with a valid/ready handshake on both sides.
// Optional feature: `PIPELINED_ADDER_SATURATE_EN adds in_sat (signed clamp on overflow).
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int STAGES    = 4,
    parameter int TAG_WIDTH = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sub,
    input  logic [TAG_WIDTH-1:0] in_tag,
`ifdef PIPELINED_ADDER_SATURATE_EN
    input  logic                 in_sat,
`endif
    input  logic [WIDTH-1:0]     operand_a,
    input  logic [WIDTH-1:0]     operand_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     result,
    output logic [TAG_WIDTH-1:0] out_tag,
    output logic                 carry_out,
    output logic                 overflow,
    output logic                 zero
);

    localparam int SLICE = WIDTH / STAGES;

    if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_param_chk
        $error("pipelined_adder: WIDTH (%0d) must be a multiple of STAGES (%0d)", WIDTH, STAGES);
    end

    // Index k holds the inputs of stage k: index 0 comes straight from the
    // ports, index k>0 is the register written by stage k-1.
    logic [WIDTH-1:0]     a_pipe   [STAGES];
    logic [WIDTH-1:0]     b_pipe   [STAGES];
    logic [WIDTH-1:0]     sum_pipe [STAGES];
    logic [TAG_WIDTH-1:0] tag_pipe [STAGES];
    stage_ctl_t           ctl_pipe [STAGES];
    stage_ctl_t           ctl_in;

    // vld_pipe[k] is the valid bit of the register behind stage k-1;
    // vld_pipe[STAGES] is the output register.
    logic [STAGES:1] vld_pipe;
    logic [STAGES:1] load;

    // Stage-0 inputs: subtract is a + ~b + 1
    assign a_pipe[0]   = operand_a;
    assign b_pipe[0]   = (in_sub == ADD_OP_SUB) ? ~operand_b : operand_b;
    assign sum_pipe[0] = '0;
    assign tag_pipe[0] = in_tag;
    assign ctl_pipe[0] = ctl_in;

    // Control word entering stage 0
    always_comb begin
        ctl_in       = '0;
        ctl_in.carry = (in_sub == ADD_OP_SUB);
        ctl_in.zero  = 1'b1;
`ifdef PIPELINED_ADDER_SATURATE_EN
        ctl_in.sat   = in_sat;
`endif
    end

    // A register loads when it or any register downstream of it is empty, or
    // the consumer takes the output: bubbles collapse, full pipe streams.
    for (genvar k = 1; k <= STAGES; k++) begin : g_load
        assign load[k] = out_ready | ~(&vld_pipe[STAGES:k]);
    end

    assign in_ready  = load[1];
    assign out_valid = vld_pipe[STAGES];

    // Valid shift register, advancing only where a register loads
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_pipe <= '0;
        end else begin
            if (load[1]) vld_pipe[1] <= in_valid;
            for (int k = 2; k <= STAGES; k++) begin
                if (load[k]) vld_pipe[k] <= vld_pipe[k-1];
            end
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [SLICE-1:0] s;
        logic             co;
        logic [WIDTH-1:0] sum_nx;
        logic             zero_nx;

        adder_slice #(.SLICE(SLICE)) u_slice (
            .a    (a_pipe[k][k*SLICE +: SLICE]),
            .b    (b_pipe[k][k*SLICE +: SLICE]),
            .cin  (ctl_pipe[k].carry),
            .sum  (s),
            .cout (co)
        );

        // Merge this slice into the partial sum built by earlier stages
        always_comb begin
            sum_nx                      = sum_pipe[k];
            sum_nx[k*SLICE +: SLICE]    = s;
        end

        assign zero_nx = ctl_pipe[k].zero & (s == '0);

        if (k < STAGES-1) begin : g_mid
            stage_ctl_t ctl_nx;

            // Control word handed to the next stage
            always_comb begin
                ctl_nx       = ctl_pipe[k];
                ctl_nx.carry = co;
                ctl_nx.zero  = zero_nx;
            end

            // Stage register: operands, partial sum, tag and control move on together
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    a_pipe[k+1]   <= '0;
                    b_pipe[k+1]   <= '0;
                    sum_pipe[k+1] <= '0;
                    tag_pipe[k+1] <= '0;
                    ctl_pipe[k+1] <= '0;
                end else if (load[k+1]) begin
                    a_pipe[k+1]   <= a_pipe[k];
                    b_pipe[k+1]   <= b_pipe[k];
                    sum_pipe[k+1] <= sum_nx;
                    tag_pipe[k+1] <= tag_pipe[k];
                    ctl_pipe[k+1] <= ctl_nx;
                end
            end
        end else begin : g_last
            logic             ovf;
            logic [WIDTH-1:0] res_fin;
            logic             zero_fin;

            // Signed overflow: operands (b already inverted for sub) agree in
            // sign but the result sign differs
            assign ovf = (a_pipe[k][WIDTH-1] == b_pipe[k][WIDTH-1]) &
                         (sum_nx[WIDTH-1] != a_pipe[k][WIDTH-1]);

            // Final result, optionally clamped to the signed range
            always_comb begin
                res_fin  = sum_nx;
                zero_fin = zero_nx;
`ifdef PIPELINED_ADDER_SATURATE_EN
                if (ctl_pipe[k].sat && ovf) begin
                    // Operand sign tells the overflow direction
                    res_fin  = a_pipe[k][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                                  : {1'b0, {(WIDTH-1){1'b1}}};
                    zero_fin = 1'b0;
                end
`endif
            end

            // Output register; holds while the consumer stalls
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    result    <= '0;
                    out_tag   <= '0;
                    carry_out <= 1'b0;
                    overflow  <= 1'b0;
                    zero      <= 1'b0;
                end else if (load[STAGES]) begin
                    result    <= res_fin;
                    out_tag   <= tag_pipe[k];
                    carry_out <= co;
                    overflow  <= ovf;
                    zero      <= zero_fin;
                end
            end
        end
    end

endmodule
